// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: operand select, single-cycle RV32I ALU,
// and an iterative 32-step multiply/divide unit that stalls the pipeline while busy.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  ex_f3_i,
    input  logic [6:0]  ex_f7_i,
    input  logic        ex_imm_sel_i,
    input  logic        ex_pc_sel_i,
    output logic [31:0] result,
    output logic        stall_req
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [31:0] op1, op2, alu_res;
    logic [4:0]  shamt;
    logic        is_mop;
    logic        unused_stall;

    assign op1    = ex_pc_sel_i ? pc_i : d1_i;
    assign op2    = ex_imm_sel_i ? imm_i : d2_i;
    assign shamt  = op2[4:0];
    assign is_mop = (ex_f7_i == 7'b0000001) && !ex_imm_sel_i && !ex_pc_sel_i;
    assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

    always_comb begin
        alu_res = '0;
        case (ex_f3_i)
            3'b000: alu_res = (ex_f7_i[5] && !ex_imm_sel_i) ? op1 - op2 : op1 + op2;
            3'b001: alu_res = op1 << shamt;
            3'b010: alu_res = {31'b0, $signed(op1) < $signed(op2)};
            3'b011: alu_res = {31'b0, op1 < op2};
            3'b100: alu_res = op1 ^ op2;
            3'b101: alu_res = ex_f7_i[5] ? 32'($signed(op1) >>> shamt) : op1 >> shamt;
            3'b110: alu_res = op1 | op2;
            default: alu_res = op1 & op2;
        endcase
    end

    // M-unit state. acc holds {hi, lo}: for multiply {partial product, remaining
    // multiplier bits}; for divide {partial remainder, dividend/quotient bits}.
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  f3_q, f3_d;
    logic        neg_p_q, neg_p_d;
    logic        neg_r_q, neg_r_d;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf;

    assign a_signed = (ex_f3_i == 3'b001) || (ex_f3_i == 3'b010) ||
                      (ex_f3_i == 3'b100) || (ex_f3_i == 3'b110);
    assign b_signed = (ex_f3_i == 3'b001) || (ex_f3_i == 3'b100) || (ex_f3_i == 3'b110);
    assign a_neg    = a_signed && op1[31];
    assign b_neg    = b_signed && op2[31];
    assign mag_a    = a_neg ? -op1 : op1;
    assign mag_b    = b_neg ? -op2 : op2;
    assign div_zero = ex_f3_i[2] && (op2 == 32'd0);
    assign div_ovf  = ex_f3_i[2] && !ex_f3_i[0] &&
                      (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // One restoring-divide step: shift in the next dividend bit, trial-subtract.
    logic [32:0] rem_sh;
    logic [33:0] div_diff;
    logic        q_bit;
    logic [31:0] new_rem;
    logic [63:0] div_next;
    assign rem_sh   = acc_q[63:31];
    assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};
    assign q_bit    = !div_diff[33];
    assign new_rem  = q_bit ? div_diff[31:0] : rem_sh[31:0];
    assign div_next = {new_rem, acc_q[30:0], q_bit};

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, m_res;
    assign prod_fix = neg_p_q ? -acc_q : acc_q;
    assign quo_fix  = neg_p_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = neg_r_q ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        m_res = '0;
        case (f3_q)
            3'b000:                 m_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: m_res = prod_fix[63:32];
            3'b100, 3'b101:         m_res = quo_fix;
            default:                m_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        f3_d    = f3_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        case (state_q)
            S_IDLE: begin
                if (is_mop) begin
                    f3_d    = ex_f3_i;
                    cnt_d   = 5'd0;
                    b_d     = mag_b;
                    acc_d   = {32'd0, mag_a};
                    neg_p_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    state_d = S_BUSY;
                    // Special divides are written in final form with no sign fix-up.
                    if (div_zero) begin
                        acc_d   = {op1, 32'hFFFF_FFFF};
                        neg_p_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {32'd0, 32'h8000_0000};
                        neg_p_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d = f3_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!stall_i[3]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign stall_req = !rst && (((state_q == S_IDLE) && is_mop) || (state_q == S_BUSY));
    assign result    = (state_q == S_DONE) ? m_res : alu_res;

endmodule
